meas_sequencer: RTL and testbench
=================================

Name: meas_sequencer

Overview:
Sequences the measurement datapath over a programmable scan of up to 4 steps. Each step sets the analogue front-end selection (input_sel, mu_sel) and the count source (count_mode). It then discards a set number of conversion frames while the front end settles. After that it gates a set number of frame results into the measurement FIFO. Sits between main_ctrl (configuration, start/abort) and the counter/prebuffer/FIFO path; its frame_tick input is the counter's per-frame capture strobe.

Parameters:
N_STEPS, 4, number of step-table entries (step index width = 2)
CFG_W, 16, width of one step-table entry

Ports:
clk_12mhz  in  1  system clock
rst_sync  in  1  asynchronous, active-high reset
cfg_wr  in  1  step-table write strobe, 1 cycle
cfg_addr  in  2  step-table entry index
cfg_data  in  16  entry: [3:0] input_sel, [6:4] mu_sel, [7] count_mode, [11:8] discard frames (0..15), [15:12] measure frames minus 1 (1..16)
num_steps  in  2  last step index (steps used = num_steps+1); sampled at start
continuous  in  1  1 = wrap to step 0 after last step; sampled at start
start  in  1  start-scan pulse
abort  in  1  abort-scan pulse
frame_tick  in  1  one-cycle pulse per completed count frame
fifo_full  in  1  measurement FIFO full
fifo_wr_en  out  1  FIFO write strobe
input_sel  out  4  front-end input select
mu_sel  out  3  gain select
count_mode  out  1  count source select to count_choise/prebuffer
step_idx  out  2  current step
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan completion (non-continuous only)
overflow  out  1  sticky: a measure frame was dropped because the FIFO was full
cfg_err  out  1  one-cycle pulse: table write rejected while busy

Behaviour:
- Reset: all outputs 0; step table cleared to 0; state IDLE.
- States:
  - IDLE: start (and no abort) -> LOAD; clears overflow; latches num_steps and continuous; step_idx <= 0.
  - LOAD: one cycle; registers table[step_idx] fields onto input_sel/mu_sel/count_mode, loads the discard counter and the measure counter. Next state is DISCARD if discard > 0, else MEASURE.
  - DISCARD: each frame_tick decrements the discard counter; on the tick that reaches 0 -> MEASURE.
  - MEASURE: each frame_tick decrements the measure counter and produces fifo_wr_en. On the tick that completes the count -> NEXT.
  - NEXT: one cycle.
    - If step_idx < latched num_steps: step_idx+1 -> LOAD.
    - Else if continuous: step_idx <= 0 -> LOAD.
    - Else: done pulse -> IDLE.
- frame_tick arriving in LOAD or NEXT is ignored (not counted).
- fifo_wr_en is combinational: frame_tick & (state==MEASURE) & ~fifo_full, so it is high in the same cycle as the tick.
- A tick in MEASURE with fifo_full: no write, overflow <= 1 (sticky until next start), and the frame still counts.
- busy = (state != IDLE).
- input_sel/mu_sel/count_mode hold their last value in IDLE.
- abort:
  - Any state -> IDLE on the next edge, with no done pulse.
  - fifo_wr_en is suppressed in the abort cycle.
  - abort wins over a simultaneous start or frame_tick.
- start while busy: ignored.
- cfg_wr:
  - While IDLE, writes table[cfg_addr] on the next edge.
  - While busy, the write is discarded and cfg_err pulses.
  - A cfg_wr coinciding with start in IDLE is accepted, and the write happens before LOAD reads the table.
- Counters: discard 4-bit down-counter; measure 5-bit down-counter loaded with field+1. No wrap below 0.

Decomposition:
- Shared package meas_seq_pkg:
  - state encoding (IDLE, LOAD, DISCARD, MEASURE, NEXT)
  - cfg_data field offsets/widths
  - N_STEPS
- One sub-module, meas_step_table: a 4x16 register file with synchronous write and asynchronous read, reset to 0.
- The FSM and counters stay in meas_sequencer.

Test Plan:
- Reset mid-MEASURE (step 1, 3 ticks in): assert rst_sync -> all outputs 0 immediately, table cleared, state IDLE.
- Single step, entry 0x20A5 (input_sel 5, mu_sel 2, count_mode 1, discard 0, measure 3), num_steps 0:
  - start -> LOAD then MEASURE; outputs 5/2/1.
  - Exactly 3 fifo_wr_en pulses, coincident with ticks 1-3.
  - done pulse 1 cycle after NEXT; busy falls.
- Two steps: entry0 discard 2 / measure 1, entry1 discard 0 / measure 2, num_steps 1:
  - 5 ticks -> writes on ticks 3, 4, 5.
  - step_idx 0 -> 1 after tick 3; input_sel changes before tick 4.
- fifo_full held during the second measure tick of a 3-frame step -> 2 writes, overflow=1, scan completes normally; next start clears overflow.
- Continuous, num_steps 0, measure 1:
  - 4 ticks -> 4 writes, no done.
  - abort with a simultaneous frame_tick -> no write, IDLE next cycle, no done.
- cfg_wr during busy -> cfg_err pulse, table unchanged (read back via a fresh scan's outputs); start during busy ignored.

Source files
------------

// File: rtl/meas_seq_pkg.sv
// Shared definitions for the measurement scan sequencer: state codes,
// step-table geometry and the layout of one step-table entry.
package meas_seq_pkg;

  localparam int unsigned N_STEPS = 4;
  localparam int unsigned STEP_W  = 2;
  localparam int unsigned CFG_W   = 16;

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned MU_W    = 3;
  localparam int unsigned DISC_W  = 4;
  localparam int unsigned MEAS_W  = 4;
  localparam int unsigned MCNT_W  = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_DISCARD = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_NEXT    = 3'd4;

  // Entry layout, MSB first: [15:12] measure-1, [11:8] discard, [7] mode, [6:4] mu, [3:0] input
  typedef struct packed {
    logic [MEAS_W-1:0] meas_m1;
    logic [DISC_W-1:0] discard;
    logic              count_mode;
    logic [MU_W-1:0]   mu_sel;
    logic [SEL_W-1:0]  input_sel;
  } step_cfg_t;

endpackage

// File: rtl/meas_seq_if.sv
// Control/status bundle between main_ctrl (master) and the scan sequencer (slave).
interface meas_seq_if;
  import meas_seq_pkg::*;

  logic                     cfg_wr;
  logic [STEP_W-1:0]        cfg_addr;
  logic [CFG_W-1:0]         cfg_data;
  logic [STEP_W-1:0]        num_steps;
  logic                     continuous;
  logic                     start;
  logic                     abort;
  logic                     frame_tick;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [SEL_W-1:0]         input_sel;
  logic [MU_W-1:0]          mu_sel;
  logic                     count_mode;
  logic [STEP_W-1:0]        step_idx;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic                     cfg_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, num_steps, continuous, start, abort,
           frame_tick, fifo_full,
    input  fifo_wr_en, input_sel, mu_sel, count_mode, step_idx, busy, done,
           overflow, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, num_steps, continuous, start, abort,
           frame_tick, fifo_full,
    output fifo_wr_en, input_sel, mu_sel, count_mode, step_idx, busy, done,
           overflow, cfg_err
  );

endinterface

// File: rtl/meas_seq_step_table.sv
// Step table: N_STEPS x CFG_W register file, synchronous write, asynchronous read.
module meas_step_table
  import meas_seq_pkg::*;
(
  input  logic              clk_12mhz,
  input  logic              rst_sync,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [CFG_W-1:0]  wr_data,
  input  logic [STEP_W-1:0] rd_addr,
  output logic [CFG_W-1:0]  rd_data
);

  logic [CFG_W-1:0] mem [N_STEPS];

  always_ff @(posedge clk_12mhz or posedge rst_sync) begin
    if (rst_sync) begin
      for (int i = 0; i < int'(N_STEPS); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/meas_sequencer.sv
// Scan sequencer: per step, select the front end, drop settling frames,
// then gate a fixed number of frame results into the measurement FIFO.
module meas_sequencer
  import meas_seq_pkg::*;
(
  input  logic      clk_12mhz,
  input  logic      rst_sync,
  meas_seq_if.slave bus
);

  logic [2:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_q, last_d;
  logic              cont_q, cont_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [MCNT_W-1:0] meas_q, meas_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [MU_W-1:0]   mu_q, mu_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              cfg_err_q, cfg_err_d;

  logic              idle;
  logic              tbl_we;
  logic [CFG_W-1:0]  tbl_rd;
  step_cfg_t         entry;

  assign idle   = (state_q == ST_IDLE);
  assign tbl_we = bus.cfg_wr & idle;
  assign entry  = step_cfg_t'(tbl_rd);

  meas_step_table u_table (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .wr_en     (tbl_we),
    .wr_addr   (bus.cfg_addr),
    .wr_data   (bus.cfg_data),
    .rd_addr   (step_q),
    .rd_data   (tbl_rd)
  );

  // State register and all datapath registers
  always_ff @(posedge clk_12mhz or posedge rst_sync) begin
    if (rst_sync) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      last_q    <= '0;
      cont_q    <= 1'b0;
      disc_q    <= '0;
      meas_q    <= '0;
      sel_q     <= '0;
      mu_q      <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      last_q    <= last_d;
      cont_q    <= cont_d;
      disc_q    <= disc_d;
      meas_q    <= meas_d;
      sel_q     <= sel_d;
      mu_q      <= mu_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state and datapath update; abort overrides everything else
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_d    = last_q;
    cont_d    = cont_q;
    disc_d    = disc_q;
    meas_d    = meas_q;
    sel_d     = sel_q;
    mu_d      = mu_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    cfg_err_d = bus.cfg_wr & ~idle;

    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_LOAD;
            ovf_d   = 1'b0;
            last_d  = bus.num_steps;
            cont_d  = bus.continuous;
            step_d  = '0;
          end
        end
        ST_LOAD: begin
          sel_d   = entry.input_sel;
          mu_d    = entry.mu_sel;
          mode_d  = entry.count_mode;
          disc_d  = entry.discard;
          meas_d  = MCNT_W'(entry.meas_m1) + MCNT_W'(1);
          state_d = (entry.discard != '0) ? ST_DISCARD : ST_MEASURE;
        end
        ST_DISCARD: begin
          if (bus.frame_tick) begin
            if (disc_q != '0) disc_d = disc_q - DISC_W'(1);
            if (disc_q <= DISC_W'(1)) state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (bus.frame_tick) begin
            if (bus.fifo_full) ovf_d = 1'b1;
            if (meas_q != '0) meas_d = meas_q - MCNT_W'(1);
            if (meas_q <= MCNT_W'(1)) state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (step_q < last_q) begin
            step_d  = step_q + STEP_W'(1);
            state_d = ST_LOAD;
          end else if (cont_q) begin
            step_d  = '0;
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_wr_en = bus.frame_tick & (state_q == ST_MEASURE) & ~bus.fifo_full & ~bus.abort;
  assign bus.input_sel  = sel_q;
  assign bus.mu_sel     = mu_q;
  assign bus.count_mode = mode_q;
  assign bus.step_idx   = step_q;
  assign bus.busy       = ~idle;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed, self-checking bench for meas_sequencer.
module tb_meas_sequencer;
  import meas_seq_pkg::*;

  logic clk_12mhz = 1'b0;
  logic rst_sync  = 1'b1;
  int   checks    = 0;
  int   failures  = 0;
  logic wr;

  meas_seq_if bus();

  meas_sequencer dut (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .bus       (bus)
  );

  always #42 clk_12mhz = ~clk_12mhz;

  task automatic clk_step();
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic wr_cfg(input logic [1:0] addr, input logic [15:0] data);
    bus.cfg_wr = 1'b1; bus.cfg_addr = addr; bus.cfg_data = data;
    clk_step();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] nsteps, input logic cont);
    bus.num_steps = nsteps; bus.continuous = cont; bus.start = 1'b1;
    clk_step();
    bus.start = 1'b0;
  endtask

  // One tick cycle; captures the combinational write strobe before the edge
  task automatic do_tick(output logic w);
    bus.frame_tick = 1'b1;
    #10 w = bus.fifo_wr_en;
    clk_step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    checks++;
    if ({bus.fifo_wr_en, bus.input_sel, bus.mu_sel, bus.count_mode, bus.step_idx,
         bus.busy, bus.done, bus.overflow, bus.cfg_err} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sel=%0d mu=%0d busy=%b done=%b", bus.input_sel, bus.mu_sel, bus.busy, bus.done);
    end
    clk_step();
    rst_sync = 1'b0;
    clk_step();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_single();
    wr_cfg(2'd0, 16'h20A5);
    pulse_start(2'd0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: busy=%b want 1", bus.busy); end
    clk_step();
    checks++;
    if ({bus.input_sel, bus.mu_sel, bus.count_mode, bus.step_idx} !== {4'd5, 3'd2, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL single_fields: sel=%0d mu=%0d mode=%b idx=%0d want 5/2/1/0", bus.input_sel, bus.mu_sel, bus.count_mode, bus.step_idx);
    end
    checks++;
    if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL single_no_tick_wr: wr=%b want 0", bus.fifo_wr_en); end
    for (int i = 1; i <= 3; i++) begin
      do_tick(wr);
      checks++;
      if (wr !== 1'b1) begin failures++; $display("FAIL single_wr%0d: wr=%b want 1", i, wr); end
      if (i < 3) clk_step();
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("FAIL single_next: busy,done=%b want 10", {bus.busy, bus.done}); end
    clk_step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin failures++; $display("FAIL single_done: busy,done=%b want 01", {bus.busy, bus.done}); end
    clk_step();
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL single_done_pulse: done=%b want 0", bus.done); end
  endtask

  task automatic test_two_steps();
    wr_cfg(2'd0, 16'h0203);
    wr_cfg(2'd1, 16'h1009);
    pulse_start(2'd1, 1'b0);
    clk_step();
    for (int i = 1; i <= 3; i++) begin
      do_tick(wr);
      checks++;
      if (wr !== (i == 3)) begin failures++; $display("FAIL two_tick%0d: wr=%b want %b", i, wr, i == 3); end
      if (i < 3) clk_step();
    end
    do_tick(wr);
    checks++;
    if ({wr, bus.step_idx, bus.input_sel} !== {1'b0, 2'd1, 4'd3}) begin
      failures++;
      $display("FAIL two_next_tick: wr=%b idx=%0d sel=%0d want 0/1/3", wr, bus.step_idx, bus.input_sel);
    end
    do_tick(wr);
    checks++;
    if ({wr, bus.input_sel} !== {1'b0, 4'd9}) begin
      failures++;
      $display("FAIL two_load_tick: wr=%b sel=%0d want 0/9", wr, bus.input_sel);
    end
    for (int i = 4; i <= 5; i++) begin
      clk_step();
      do_tick(wr);
      checks++;
      if (wr !== 1'b1) begin failures++; $display("FAIL two_tick%0d: wr=%b want 1", i, wr); end
    end
    clk_step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin failures++; $display("FAIL two_done: busy,done=%b want 01", {bus.busy, bus.done}); end
  endtask

  task automatic test_overflow();
    wr_cfg(2'd0, 16'h2001);
    pulse_start(2'd0, 1'b0);
    clk_step();
    do_tick(wr);
    checks++;
    if (wr !== 1'b1) begin failures++; $display("FAIL ovf_tick1: wr=%b want 1", wr); end
    bus.fifo_full = 1'b1;
    do_tick(wr);
    bus.fifo_full = 1'b0;
    checks++;
    if ({wr, bus.overflow} !== 2'b01) begin failures++; $display("FAIL ovf_full_tick: wr,ovf=%b want 01", {wr, bus.overflow}); end
    do_tick(wr);
    checks++;
    if (wr !== 1'b1) begin failures++; $display("FAIL ovf_tick3: wr=%b want 1", wr); end
    clk_step();
    checks++;
    if ({bus.done, bus.overflow} !== 2'b11) begin failures++; $display("FAIL ovf_done: done,ovf=%b want 11", {bus.done, bus.overflow}); end
    pulse_start(2'd0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: ovf=%b want 0", bus.overflow); end
    bus.abort = 1'b1; clk_step(); bus.abort = 1'b0;
  endtask

  task automatic test_continuous();
    wr_cfg(2'd0, 16'h0002);
    pulse_start(2'd0, 1'b1);
    clk_step();
    for (int i = 1; i <= 4; i++) begin
      do_tick(wr);
      checks++;
      if ({wr, bus.done} !== 2'b10) begin failures++; $display("FAIL cont_tick%0d: wr,done=%b want 10", i, {wr, bus.done}); end
      clk_step();
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("FAIL cont_wrap%0d: busy,done=%b want 10", i, {bus.busy, bus.done}); end
      clk_step();
    end
    bus.abort = 1'b1;
    do_tick(wr);
    bus.abort = 1'b0;
    checks++;
    if ({wr, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL cont_abort: wr,busy,done=%b want 000", {wr, bus.busy, bus.done});
    end
    clk_step();
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL cont_abort_done: done=%b want 0", bus.done); end
  endtask

  task automatic test_cfg_busy();
    wr_cfg(2'd0, 16'h000C);
    pulse_start(2'd0, 1'b0);
    clk_step();
    wr_cfg(2'd0, 16'h0007);
    checks++;
    if (bus.cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse: cfg_err=%b want 1", bus.cfg_err); end
    pulse_start(2'd0, 1'b0);
    checks++;
    if ({bus.cfg_err, bus.busy, bus.input_sel} !== {1'b0, 1'b1, 4'd12}) begin
      failures++;
      $display("FAIL cfg_start_busy: err=%b busy=%b sel=%0d want 0/1/12", bus.cfg_err, bus.busy, bus.input_sel);
    end
    do_tick(wr);
    clk_step();
    checks++;
    if ({wr, bus.done} !== 2'b11) begin failures++; $display("FAIL cfg_scan_done: wr,done=%b want 11", {wr, bus.done}); end
    pulse_start(2'd0, 1'b0);
    clk_step();
    checks++;
    if (bus.input_sel !== 4'd12) begin failures++; $display("FAIL cfg_table_kept: sel=%0d want 12", bus.input_sel); end
    bus.abort = 1'b1; clk_step(); bus.abort = 1'b0;
    bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 16'h0006;
    pulse_start(2'd0, 1'b0);
    bus.cfg_wr = 1'b0;
    clk_step();
    checks++;
    if ({bus.cfg_err, bus.input_sel} !== {1'b0, 4'd6}) begin
      failures++;
      $display("FAIL cfg_with_start: err=%b sel=%0d want 0/6", bus.cfg_err, bus.input_sel);
    end
    bus.abort = 1'b1; clk_step(); bus.abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_cfg(2'd0, 16'h0000);
    wr_cfg(2'd1, 16'hF0A5);
    pulse_start(2'd1, 1'b0);
    clk_step();
    do_tick(wr);
    clk_step();
    clk_step();
    for (int i = 0; i < 3; i++) begin do_tick(wr); clk_step(); end
    checks++;
    if ({bus.busy, bus.step_idx, bus.input_sel} !== {1'b1, 2'd1, 4'd5}) begin
      failures++;
      $display("FAIL mid_pre_reset: busy=%b idx=%0d sel=%0d want 1/1/5", bus.busy, bus.step_idx, bus.input_sel);
    end
    #5 rst_sync = 1'b1;
    #1;
    checks++;
    if ({bus.input_sel, bus.mu_sel, bus.count_mode, bus.step_idx, bus.busy, bus.done,
         bus.overflow, bus.cfg_err} !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: sel=%0d mu=%0d idx=%0d busy=%b", bus.input_sel, bus.mu_sel, bus.step_idx, bus.busy);
    end
    clk_step();
    rst_sync = 1'b0;
    pulse_start(2'd1, 1'b0);
    clk_step();
    do_tick(wr);
    clk_step();
    clk_step();
    checks++;
    if ({bus.step_idx, bus.input_sel, bus.mu_sel, bus.count_mode} !== {2'd1, 4'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_table_cleared: idx=%0d sel=%0d mu=%0d mode=%b want 1/0/0/0", bus.step_idx, bus.input_sel, bus.mu_sel, bus.count_mode);
    end
    do_tick(wr);
    clk_step();
    checks++;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL mid_one_frame: done=%b want 1", bus.done); end
  endtask

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.num_steps = '0; bus.continuous = 1'b0; bus.start = 1'b0;
    bus.abort = 1'b0; bus.frame_tick = 1'b0; bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_two_steps();
    test_overflow();
    test_continuous();
    test_cfg_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
